// File: rtl/mem_wb_sender.sv
// MEM/WB stage sender: hands ALU results straight to writeback and issues a word read for loads,
// extending the returned data. Optional load timeout is enabled by defining MEM_WB_TIMEOUT_EN.
module mem_wb_sender (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        wen_i,
  input  logic        wsel_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] alu_result_i,
  input  logic [2:0]  load_op_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_we_o,
  output logic        wb_wen_o,
  output logic        wb_wsel_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_alu_result_o,
  output logic [31:0] wb_mem_result_o
`ifdef MEM_WB_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StSend} state_e;

  state_e      state_q, state_d;
  logic        wen_q, wen_d;
  logic        wsel_q, wsel_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] alu_q, alu_d;
  logic [2:0]  load_op_q, load_op_d;
  logic [31:0] mem_result_q, mem_result_d;
`ifdef MEM_WB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
`endif

  logic [31:0] byte_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic        send;

  // Lane selection uses the captured byte address; addr[0] is ignored for halfwords.
  always_comb begin
    byte_shift = mem_rdata_i >> {alu_q[1:0], 3'b000};
    byte_sel   = byte_shift[7:0];
    half_sel   = alu_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (load_op_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext_data = mem_rdata_i;
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wen_d        = wen_q;
    wsel_d       = wsel_q;
    waddr_d      = waddr_q;
    alu_d        = alu_q;
    load_op_d    = load_op_q;
    mem_result_d = mem_result_q;
`ifdef MEM_WB_TIMEOUT_EN
    cnt_d        = cnt_q;
    to_d         = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          wen_d        = wen_i;
          wsel_d       = wsel_i;
          waddr_d      = waddr_i;
          alu_d        = alu_result_i;
          load_op_d    = load_op_i;
          mem_result_d = 32'd0;
          state_d      = wsel_i ? StWaitMem : StSend;
`ifdef MEM_WB_TIMEOUT_EN
          cnt_d        = 8'd0;
          to_d         = 1'b0;
`endif
        end
      end
      StWaitMem: begin
        if (mem_ack_i) begin
          mem_result_d = ext_data;
          state_d      = StSend;
        end
`ifdef MEM_WB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          // Counter hitting 255 abandons the load; a same-cycle ack wins above.
          if (cnt_d == 8'hFF) begin
            mem_result_d = 32'd0;
            to_d         = 1'b1;
            state_d      = StSend;
          end
        end
`endif
      end
      StSend:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wen_q        <= 1'b0;
      wsel_q       <= 1'b0;
      waddr_q      <= 5'd0;
      alu_q        <= 32'd0;
      load_op_q    <= 3'd0;
      mem_result_q <= 32'd0;
`ifdef MEM_WB_TIMEOUT_EN
      cnt_q        <= 8'd0;
      to_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      wsel_q       <= wsel_d;
      waddr_q      <= waddr_d;
      alu_q        <= alu_d;
      load_op_q    <= load_op_d;
      mem_result_q <= mem_result_d;
`ifdef MEM_WB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      to_q         <= to_d;
`endif
    end
  end

  // Outputs are masked by rst so the reset values hold while reset is still asserted.
  always_comb begin
    send            = (state_q == StSend) && !rst;
    ready_o         = (state_q == StIdle) || rst;
    mem_req_o       = (state_q == StWaitMem) && !rst;
    mem_addr_o      = mem_req_o ? {alu_q[31:2], 2'b00} : 32'd0;
    wb_we_o         = send;
    wb_wen_o        = send & wen_q;
    wb_wsel_o       = send & wsel_q;
    wb_waddr_o      = send ? waddr_q : 5'd0;
    wb_alu_result_o = send ? alu_q : 32'd0;
    wb_mem_result_o = send ? mem_result_q : 32'd0;
`ifdef MEM_WB_TIMEOUT_EN
    timeout_o       = send & to_q;
`endif
  end

endmodule

// File: tb/tb_mem_wb_sender.sv
// Scoreboard bench for mem_wb_sender: stimulus pushes expected writebacks, a negedge monitor
// pops and compares on every wb_we_o pulse and checks all wb_* are zero otherwise.
module tb_mem_wb_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        wen_i = 1'b0;
  logic        wsel_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] alu_result_i = '0;
  logic [2:0]  load_op_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        wb_we_o;
  logic        wb_wen_o;
  logic        wb_wsel_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_alu_result_o;
  logic [31:0] wb_mem_result_o;
`ifdef MEM_WB_TIMEOUT_EN
  logic        timeout_o;
`endif

  mem_wb_sender dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .wen_i          (wen_i),
    .wsel_i         (wsel_i),
    .waddr_i        (waddr_i),
    .alu_result_i   (alu_result_i),
    .load_op_i      (load_op_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .wb_we_o        (wb_we_o),
    .wb_wen_o       (wb_wen_o),
    .wb_wsel_o      (wb_wsel_o),
    .wb_waddr_o     (wb_waddr_o),
    .wb_alu_result_o(wb_alu_result_o),
    .wb_mem_result_o(wb_mem_result_o)
`ifdef MEM_WB_TIMEOUT_EN
    ,
    .timeout_o      (timeout_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic        wsel;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic to_act;
`ifdef MEM_WB_TIMEOUT_EN
    to_act = timeout_o;
`else
    to_act = 1'b0;
`endif
    if (wb_we_o === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wb_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_wen", {31'd0, wb_wen_o}, {31'd0, e.wen});
        chk("wb_wsel", {31'd0, wb_wsel_o}, {31'd0, e.wsel});
        chk("wb_waddr", {27'd0, wb_waddr_o}, {27'd0, e.waddr});
        chk("wb_alu_result", wb_alu_result_o, e.alu);
        chk("wb_mem_result", wb_mem_result_o, e.mem);
`ifdef MEM_WB_TIMEOUT_EN
        chk("timeout", {31'd0, to_act}, {31'd0, e.to});
`endif
      end
    end else begin
      chk("wb_idle_zero", {wb_wen_o, wb_wsel_o, wb_waddr_o, wb_alu_result_o[24:0]} |
          wb_alu_result_o | wb_mem_result_o | {31'd0, to_act} | {31'd0, wb_we_o}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ready_o !== 1'b1) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push(input logic wen, input logic wsel, input logic [4:0] waddr,
                      input logic [31:0] alu, input logic [31:0] mem, input logic to);
    exp_t e;
    e.wen = wen; e.wsel = wsel; e.waddr = waddr; e.alu = alu; e.mem = mem; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic wen, input logic wsel, input logic [4:0] waddr,
                       input logic [31:0] alu, input logic [2:0] op);
    valid_i = 1'b1; wen_i = wen; wsel_i = wsel; waddr_i = waddr;
    alu_result_i = alu; load_op_i = op;
  endtask

  task automatic do_alu(input logic wen, input logic [4:0] waddr, input logic [31:0] alu);
    wait_idle();
    push(wen, 1'b0, waddr, alu, 32'd0, 1'b0);
    drive(wen, 1'b0, waddr, alu, 3'b000);
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  // delay = number of WAIT_MEM cycles before the ack cycle (0 = ack in first cycle)
  task automatic do_load(input logic [4:0] waddr, input logic [31:0] addr, input logic [2:0] op,
                         input int delay, input logic [31:0] rdata, input logic [31:0] want,
                         input logic [31:0] want_addr);
    wait_idle();
    push(1'b1, 1'b1, waddr, addr, want, 1'b0);
    drive(1'b1, 1'b1, waddr, addr, op);
    tick();
    valid_i = 1'b0;
    chk("mem_req_wait", {31'd0, mem_req_o}, 32'd1);
    chk("mem_addr", mem_addr_o, want_addr);
    chk("ready_wait", {31'd0, ready_o}, 32'd0);
    repeat (delay) tick();
    chk("mem_req_before_ack", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = rdata;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
    chk("mem_req_send", {31'd0, mem_req_o}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pulses;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, ready_o}, 32'd1);

    // ALU pass-through
    do_alu(1'b1, 5'd5, 32'h0000_1234);
    do_alu(1'b0, 5'd31, 32'hFFFF_0001);

    // Loads: lb, lhu upper lane, lw, lh, lbu, lb positive, illegal op
    do_load(5'd1, 32'h0000_1003, 3'b000, 3, 32'h80FF_FF7F, 32'hFFFF_FF80, 32'h0000_1000);
    do_load(5'd2, 32'h0000_2002, 3'b101, 0, 32'hBEEF_0000, 32'h0000_BEEF, 32'h0000_2000);
    do_load(5'd3, 32'h0000_3001, 3'b010, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_3000);
    do_load(5'd4, 32'h0000_4001, 3'b001, 2, 32'h1234_8001, 32'hFFFF_8001, 32'h0000_4000);
    do_load(5'd6, 32'h0000_5001, 3'b100, 0, 32'hAABB_CCDD, 32'h0000_00CC, 32'h0000_5000);
    do_load(5'd7, 32'h0000_6000, 3'b000, 0, 32'h0000_007F, 32'h0000_007F, 32'h0000_6000);
    do_load(5'd8, 32'h0000_7003, 3'b011, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_7000);

    // Reset while waiting: instruction abandoned, later ack ignored
    wait_idle();
    drive(1'b1, 1'b1, 5'd9, 32'h0000_8000, 3'b010);
    tick();
    valid_i = 1'b0;
    chk("rw_mem_req", {31'd0, mem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_ready_in_rst", {31'd0, ready_o}, 32'd1);
    chk("rw_mem_req_in_rst", {31'd0, mem_req_o}, 32'd0);
    tick();
    rst = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    tick();
    mem_ack_i = 1'b0;
    repeat (3) tick();
    chk("rw_ready_after", {31'd0, ready_o}, 32'd1);
    chk("rw_mem_req_after", {31'd0, mem_req_o}, 32'd0);

    // Spurious ack held high plus back-to-back valid
    mem_ack_i = 1'b1; mem_rdata_i = 32'h2222_2222;
    tick();
    chk("spur_ready", {31'd0, ready_o}, 32'd1);
    push(1'b1, 1'b0, 5'd10, 32'h0000_00AA, 32'd0, 1'b0);
    push(1'b1, 1'b0, 5'd11, 32'h0000_00BB, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 5'd10, 32'h0000_00AA, 3'b000);
    tick();
    chk("b2b_we_first", {31'd0, wb_we_o}, 32'd1);
    chk("b2b_ready_send", {31'd0, ready_o}, 32'd0);
    drive(1'b1, 1'b0, 5'd11, 32'h0000_00BB, 3'b000);
    tick();
    chk("b2b_ready_idle", {31'd0, ready_o}, 32'd1);
    chk("b2b_we_gap", {31'd0, wb_we_o}, 32'd0);
    tick();
    valid_i = 1'b0;
    chk("b2b_we_second", {31'd0, wb_we_o}, 32'd1);
    tick();
    mem_ack_i = 1'b0;
    tick();

`ifdef MEM_WB_TIMEOUT_EN
    begin
      int req_cycles = 0;
      wait_idle();
      push(1'b1, 1'b1, 5'd12, 32'h0000_9000, 32'd0, 1'b1);
      drive(1'b1, 1'b1, 5'd12, 32'h0000_9000, 3'b010);
      tick();
      valid_i = 1'b0;
      while (mem_req_o === 1'b1 && req_cycles < 400) begin
        req_cycles++;
        tick();
      end
      chk("timeout_req_cycles", req_cycles, 32'd255);
      chk("timeout_we", {31'd0, wb_we_o}, 32'd1);
      tick();
    end
`endif

    repeat (2) tick();
    exp_pulses = 2 + 7 + 2;
`ifdef MEM_WB_TIMEOUT_EN
    exp_pulses = exp_pulses + 1;
`endif
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("pulse_count", pulses, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_sender.md
MEM_WB_SENDER -- requirements
Module: mem_wb_sender

Interface
REQ-001 The block SHALL use one clock, clk; reset is rst, synchronous and active-high; all state SHALL update on the rising edge of clk only.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  upstream (EXU) instruction valid
- ready_o  out  1  block can accept an instruction
- wen_i  in  1  register write enable
- wsel_i  in  1  0 = ALU result, 1 = load
- waddr_i  in  5  destination register
- alu_result_i  in  32  ALU result; byte address for loads
- load_op_i  in  3  funct3 of the load
- mem_req_o  out  1  memory read request
- mem_addr_o  out  32  word-aligned read address
- mem_ack_i  in  1  read data valid
- mem_rdata_i  in  32  read data word
- wb_we_o  out  1  writeback register load strobe
- wb_wen_o  out  1  forwarded wen
- wb_wsel_o  out  1  forwarded wsel
- wb_waddr_o  out  5  forwarded waddr
- wb_alu_result_o  out  32  forwarded ALU result
- wb_mem_result_o  out  32  extended load data
- timeout_o  out  1  load abandoned; present only with MEM_WB_TIMEOUT_EN

Function
REQ-003 The block SHALL implement states IDLE, WAIT_MEM and SEND.
REQ-004 ready_o SHALL be 1 in IDLE only; an instruction is accepted when valid_i and ready_o are both 1 at a clock edge.
REQ-005 On accept with wsel_i = 0: wen_i, wsel_i, waddr_i and alu_result_i are captured, and the next state is SEND (wb_we_o high one cycle after accept).
REQ-006 On accept with wsel_i = 1: the next state is WAIT_MEM.
- mem_req_o = 1 throughout WAIT_MEM.
- mem_addr_o = {captured address[31:2], 2'b00}.
REQ-007 In WAIT_MEM, mem_ack_i = 1 SHALL capture the extended mem_rdata_i into wb_mem_result_o and move to SEND; the ack may arrive in the first WAIT_MEM cycle.
REQ-008 mem_ack_i SHALL be ignored in IDLE and SEND.
REQ-009 In SEND, wb_we_o SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; back-to-back accepts are therefore spaced by at least 2 cycles.
REQ-010 Whenever wb_we_o = 0, every wb_* output SHALL be 0.
REQ-011 Load extension uses byte lane addr[1:0] and halfword lane addr[1]; addr[0] is ignored for halfwords:
- 000 lb: sign-extended byte
- 001 lh: sign-extended halfword
- 010 lw: full word
- 100 lbu: zero-extended byte
- 101 lhu: zero-extended halfword
- any other code: 0
REQ-012 For wsel = 0 instructions, wb_mem_result_o SHALL be 0 in SEND.

Reset
REQ-013 With rst = 1 at a clock edge, the state SHALL become IDLE and all captured registers SHALL be cleared.
REQ-014 During and after reset: ready_o = 1 and all of mem_req_o, mem_addr_o, wb_* and timeout_o = 0.
REQ-015 Reset asserted during WAIT_MEM or SEND SHALL abandon the instruction with no wb_we_o pulse; a later mem_ack_i SHALL be ignored.

Configuration
REQ-016 With MEM_WB_TIMEOUT_EN defined:
- An 8-bit counter clears on entry to WAIT_MEM and increments in each WAIT_MEM cycle without ack.
- When the counter reaches 255 with no ack, the block SHALL drop mem_req_o and go to SEND with wb_mem_result_o = 0.
- timeout_o = 1 coincides with that wb_we_o pulse.
- An ack in the same cycle the counter reaches 255 takes priority.
REQ-017 Without MEM_WB_TIMEOUT_EN, the timeout_o port and the counter SHALL be absent, and WAIT_MEM SHALL wait indefinitely.

Verification
REQ-018 ALU pass-through: accept wen=1, wsel=0, waddr=5, alu=0x1234 at cycle T -> wb_we_o=1 at T+1 with wb_waddr_o=5 and wb_alu_result_o=0x1234; all wb_* = 0 at T+2.
REQ-019 lb, sign-extended: address 0x1003, load_op=000, ack after 3 cycles with rdata 0x80FF_FF7F -> mem_addr_o=0x1000; wb_mem_result_o=0xFFFF_FF80 with a single wb_we_o pulse.
REQ-020 lhu, upper lane: address 0x2002, load_op=101, rdata 0xBEEF_0000, ack in the first WAIT_MEM cycle -> wb_mem_result_o=0x0000_BEEF.
REQ-021 Reset while waiting: assert rst for one cycle in WAIT_MEM, then pulse mem_ack_i -> no wb_we_o pulse and ready_o=1.
REQ-022 Spurious ack plus handshake: mem_ack_i=1 in IDLE, and valid_i held high for two instructions -> ack ignored, second accept one cycle after the first SEND.
REQ-023 Timeout (MEM_WB_TIMEOUT_EN): load with no ack -> mem_req_o high for 255 cycles, then wb_we_o=1 and timeout_o=1 with wb_mem_result_o=0.
